// File: rtl/temp_pkg.sv
// Shared definitions for the temperature sensor SPI sampler.
//   state_t       : sampler FSM states
//   *_DEF         : default frame length, SCLK divider and temperature field width
//   tick_latency  : clk cycles from the tick cycle to the sample_valid cycle
package temp_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int unsigned FRAME_BITS_DEF = 16;
    localparam int unsigned CLK_DIV_DEF    = 4;
    localparam int unsigned TEMP_W_DEF     = 12;

    // One cycle to accept the tick, then SETUP, FRAME_BITS low/high pairs and HOLD.
    function automatic int unsigned tick_latency(input int unsigned frame_bits,
                                                 input int unsigned clk_div);
        return 1 + clk_div * (2 * frame_bits + 2);
    endfunction

endpackage

// File: rtl/temp_spi_shift.sv
// SPI mode-0 receive engine for the temperature sensor.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   start        : one-cycle pulse, begins a frame with a fresh low half-period
//   miso         : raw sensor data, synchronised here
//   sclk         : serial clock, idles low
//   done_c       : high in the final cycle of the last high half-period
//   frame        : received bits, MSB first
module temp_spi_shift
    import temp_pkg::*;
#(
    parameter int unsigned FRAME_BITS = FRAME_BITS_DEF,
    parameter int unsigned CLK_DIV    = CLK_DIV_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  done_c,
    output logic [FRAME_BITS-1:0] frame
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(FRAME_BITS);

    logic [DIV_W-1:0] div_q;
    logic [BIT_W-1:0] bit_q;
    logic             active_q;
    logic             miso_s1;
    logic             miso_s2;
    logic             half_end_c;
    logic             last_bit_c;

    // Terminal count of the current half-period; sclk itself is the phase.
    assign half_end_c = active_q && (div_q == DIV_W'(CLK_DIV - 1));
    assign last_bit_c = (bit_q == BIT_W'(FRAME_BITS - 1));
    assign done_c     = half_end_c && sclk && last_bit_c;

    // Two-flop synchroniser for the asynchronous miso line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            miso_s1 <= miso;
            miso_s2 <= miso_s1;
        end
    end

    // Half-period divider, sclk phase, bit counter and shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            sclk     <= 1'b0;
            frame    <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            div_q    <= '0;
            bit_q    <= '0;
            sclk     <= 1'b0;
        end else if (active_q) begin
            if (half_end_c) begin
                div_q <= '0;
                if (!sclk) begin
                    // Sample on the edge that raises sclk.
                    sclk  <= 1'b1;
                    frame <= {frame[FRAME_BITS-2:0], miso_s2};
                end else begin
                    sclk  <= 1'b0;
                    bit_q <= bit_q + BIT_W'(1);
                    if (last_bit_c) begin
                        active_q <= 1'b0;
                    end
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/temp_spi_sampler.sv
// Reads one temperature sensor frame per interval tick and block-averages good samples.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   tick          : start strobe from the interval counter wrap
//   miso          : sensor serial data (asynchronous)
//   cs_n, sclk    : sensor chip select (active low) and serial clock
//   busy          : tick accepted until the sample_valid cycle inclusive
//   sample        : last good temperature field
//   sample_valid  : frame complete pulse (good or faulted)
//   fault         : fault bit of the last frame
//   avg           : last block average
//   avg_valid     : pulse when avg updates
//   overrun       : sticky, tick seen while not idle
module temp_spi_sampler
    import temp_pkg::*;
#(
    parameter int unsigned FRAME_BITS = FRAME_BITS_DEF,
    parameter int unsigned TEMP_MSB   = 14,
    parameter int unsigned TEMP_LSB   = 3,
    parameter int unsigned FAULT_BIT  = 2,
    parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
    parameter int unsigned AVG_LOG2   = 3,
    localparam int unsigned TEMP_W    = TEMP_MSB - TEMP_LSB + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              miso,
    output logic              cs_n,
    output logic              sclk,
    output logic              busy,
    output logic [TEMP_W-1:0] sample,
    output logic              sample_valid,
    output logic              fault,
    output logic [TEMP_W-1:0] avg,
    output logic              avg_valid,
    output logic              overrun
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned ACC_W = TEMP_W + AVG_LOG2;
    localparam int unsigned CNT_W = AVG_LOG2 + 1;

    state_t                  state_q;
    state_t                  state_nxt;
    logic [DIV_W-1:0]        cnt_q;
    logic [DIV_W-1:0]        cnt_nxt;
    logic                    start_c;
    logic                    shift_done_c;
    logic [FRAME_BITS-1:0]   frame;
    logic                    cs_n_nxt_c;
    logic                    busy_nxt_c;
    logic                    finish_c;
    logic [TEMP_W-1:0]       field_c;
    logic                    fault_bit_c;
    logic [ACC_W-1:0]        sum_c;
    logic                    block_full_c;
    logic [ACC_W-1:0]        acc_q;
    logic [CNT_W-1:0]        good_q;
    logic                    unused_frame_c;

    temp_spi_shift #(
        .FRAME_BITS (FRAME_BITS),
        .CLK_DIV    (CLK_DIV)
    ) u_shift (
        .clk    (clk),
        .rst    (rst),
        .start  (start_c),
        .miso   (miso),
        .sclk   (sclk),
        .done_c (shift_done_c),
        .frame  (frame)
    );

    // Field extraction and running block sum.
    assign field_c        = frame[TEMP_MSB:TEMP_LSB];
    assign fault_bit_c    = frame[FAULT_BIT];
    assign sum_c          = acc_q + ACC_W'(field_c);
    assign block_full_c   = (good_q == CNT_W'((2 ** AVG_LOG2) - 1));
    // Frame bits outside the temperature and fault fields carry nothing we use.
    assign unused_frame_c = ^frame;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // Next state, phase counter for SETUP/HOLD, and next values of registered outputs.
    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        start_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_nxt = SETUP;
                    cnt_nxt   = '0;
                end
            end
            SETUP: begin
                if (cnt_q == DIV_W'(CLK_DIV - 1)) begin
                    state_nxt = SHIFT;
                    start_c   = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (shift_done_c) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == DIV_W'(CLK_DIV - 1)) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + DIV_W'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        cs_n_nxt_c = !(state_nxt inside {SETUP, SHIFT, HOLD});
        busy_nxt_c = (state_nxt != IDLE);
        finish_c   = (state_q == HOLD) && (state_nxt == DONE);
    end

    // Registered outputs; results land in the DONE cycle together with sample_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_n         <= 1'b1;
            busy         <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            fault        <= 1'b0;
            avg          <= '0;
            avg_valid    <= 1'b0;
            overrun      <= 1'b0;
            acc_q        <= '0;
            good_q       <= '0;
        end else begin
            cs_n         <= cs_n_nxt_c;
            busy         <= busy_nxt_c;
            sample_valid <= finish_c;
            avg_valid    <= 1'b0;
            if (tick && (state_q != IDLE)) begin
                overrun <= 1'b1;
            end
            if (finish_c) begin
                fault <= fault_bit_c;
                if (!fault_bit_c) begin
                    sample <= field_c;
                    if (block_full_c) begin
                        avg       <= TEMP_W'(sum_c >> AVG_LOG2);
                        avg_valid <= 1'b1;
                        acc_q     <= '0;
                        good_q    <= '0;
                    end else begin
                        acc_q  <= sum_c;
                        good_q <= good_q + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: doc/temp_spi_sampler.md
Name: temp_spi_sampler

Overview:
Consumes the periodic wrap tick of the sample-interval counter and performs one serial read of an external temperature sensor per tick. Interface is SPI mode 0, read-only, MSB first. Extracts the temperature field and fault bit from each frame, and produces per-sample and block-averaged temperatures for the display/compare stage. Sits directly downstream of the interval counter; the wrap decode (counter value == MAX_VAL) drives tick.

Parameters:
FRAME_BITS, 16, bits clocked per sensor frame (8..32)
TEMP_MSB, 14, frame bit index of the temperature field MSB
TEMP_LSB, 3, frame bit index of the temperature field LSB; TEMP_W = TEMP_MSB-TEMP_LSB+1 (12)
FAULT_BIT, 2, frame bit index of the sensor open/fault flag
CLK_DIV, 4, clk cycles per SCLK half-period (>=1)
AVG_LOG2, 3, log2 of good samples per average (0 = every sample)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (asserts immediately, releases synchronously to clk)
tick  input  1  one-cycle start strobe from the interval counter wrap
miso  input  1  sensor serial data
cs_n  output  1  sensor chip select, active low
sclk  output  1  sensor serial clock, idles low
busy  output  1  high from tick acceptance until sample_valid cycle inclusive
sample  output  TEMP_W  last good temperature field
sample_valid  output  1  one-cycle pulse, frame complete (good or faulted)
fault  output  1  fault bit of the last frame; sample not updated when set
avg  output  TEMP_W  last block average
avg_valid  output  1  one-cycle pulse when avg updates
overrun  output  1  sticky; tick arrived while busy; cleared only by reset

Behaviour:
- Reset: cs_n=1, sclk=0, busy=0, sample=0, sample_valid=0, fault=0, avg=0, avg_valid=0, overrun=0, accumulator=0, good-sample count=0, state=IDLE.
- States: IDLE, SETUP, SHIFT, HOLD, DONE.
- IDLE: tick=1 -> SETUP; cs_n=0 and busy=1 from the next cycle.
- SETUP: CLK_DIV cycles with sclk=0 -> SHIFT.
- SHIFT: each bit is CLK_DIV cycles sclk=0, then CLK_DIV cycles sclk=1. miso is sampled on the clk edge that drives sclk 0->1, shifted in MSB first. After FRAME_BITS high phases, sclk returns to 0 -> HOLD.
- HOLD: CLK_DIV cycles, cs_n=0, sclk=0 -> DONE.
- DONE, single cycle: cs_n=1, sample_valid=1, fault=frame[FAULT_BIT]; -> IDLE next cycle, busy=0.
- Latency: tick at cycle T -> sample_valid at T+1+CLK_DIV*(2*FRAME_BITS+2). Defaults: T+137.
- Earliest re-accept: a tick one cycle after DONE.
- Good frame (fault bit=0): sample=frame[TEMP_MSB:TEMP_LSB]. Field is added to an accumulator of width TEMP_W+AVG_LOG2, which cannot overflow. Good count increments.
- When the count reaches 2^AVG_LOG2: in the same DONE cycle, avg=(acc+field)>>AVG_LOG2 (truncating), avg_valid=1, accumulator and count cleared.
- Faulted frame: sample, accumulator and count unchanged; fault=1. The next good frame clears fault.
- tick while state!=IDLE: ignored, overrun set to 1. A tick in the DONE cycle counts as overrun.
- Reset mid-frame: immediate return to reset values, cs_n high asynchronously. A partial frame is discarded.
- miso is treated as asynchronous: double-flop synchronised before sampling. Sensor timing budget is covered by CLK_DIV>=2 at the system clock rate.

Decomposition:
- Shared package temp_pkg holds:
  - the state enum;
  - the defaults FRAME_BITS_DEF, CLK_DIV_DEF, TEMP_W_DEF;
  - a function for the tick-to-valid latency, reused by the bench.
- One natural sub-module: temp_spi_shift. It owns the half-period divider, sclk generation, bit counter and shift register, and exposes start, done and frame.
- The averaging and FSM stay in temp_spi_sampler.

Test Plan:
- Reset then single tick, sensor model returns 16'h1908 (field 12'h321, fault 0) -> cs_n low T+1..T+136. 16 sclk rising edges, high phase 4 cycles each. sample_valid and sample=12'h321 at T+137; fault=0; busy drops T+138.
- Frame 16'h0004 (fault bit set) after a good 12'h321 -> fault=1, sample stays 12'h321, no avg_valid.
- 8 good frames with fields 10,10,10,10,10,10,10,17 -> avg_valid only on the 8th sample_valid, avg=10 (87>>3 truncated).
- Tick pulsed at T+50 during a frame -> overrun=1 and stays 1; frame completes normally at T+137, and no second frame starts.
- rst asserted at T+60 mid-SHIFT -> cs_n=1 and sclk=0 without waiting for clk, all outputs at reset values. A tick after release yields a clean full frame.
- Back-to-back: tick exactly one cycle after sample_valid -> accepted, overrun stays 0.
